nrisc_ddata_mem: RTL and testbench

Data-memory responder for the NRISC D-Data port: the target end of the bus the core drives with DDATA_CORE_addr/in/load/write/ctrl. Services word and byte loads/stores into a synchronous single-port word array. Sub-word stores use a two-cycle read-modify-write with a busy indication. Load data is registered and feeds the core's write-back mux.

---
 rtl/nrisc_ddata_mem.sv | 111 +++++++++++
 tb/tb_nrisc_ddata_mem.sv | 135 +++++++++++++
 2 files changed

// File: rtl/nrisc_ddata_mem.sv
// NRISC D-Data port responder: word/byte loads and stores into a synchronous word array.
// Byte stores use a two-cycle read-modify-write and report busy while the merge is pending.
module nrisc_ddata_mem #(
    parameter int TAM     = 16,
    parameter int N_DData = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DData-1:0] DDATA_CORE_addr,
    input  logic [TAM-1:0]     DDATA_CORE_in,
    input  logic               DDATA_CORE_load,
    input  logic               DDATA_CORE_write,
    input  logic [2:0]         DDATA_CORE_ctrl,
    output logic [TAM-1:0]     DDATA_CORE_out,
    output logic               DDATA_CORE_busy,
    output logic               DDATA_CORE_err
);
    typedef enum logic {IDLE, RMW} state_t;

    state_t state_q, state_d;

    logic [TAM-1:0]     mem [0:2**N_DData-1];
    logic [N_DData-1:0] addr_q;
    logic [7:0]         byte_q;
    logic               lane_q;
    logic [TAM-1:0]     hold_q;
    logic [TAM-1:0]     out_q, out_d;
    logic               err_q, err_d;

    logic               idle;
    logic               byte_wr;
    logic [TAM-1:0]     rd_word;
    logic [7:0]         rd_byte;
    logic [TAM-1:0]     rd_ext;
    logic [TAM-1:0]     merged;
    logic               mem_we;
    logic [N_DData-1:0] mem_waddr;
    logic [TAM-1:0]     mem_wdata;

    assign idle    = (state_q == IDLE);
    assign byte_wr = idle && DDATA_CORE_write && DDATA_CORE_ctrl[0];
    assign rd_word = mem[DDATA_CORE_addr];
    assign rd_byte = DDATA_CORE_ctrl[1] ? rd_word[15:8] : rd_word[7:0];
    assign rd_ext  = DDATA_CORE_ctrl[2] ? {{(TAM-8){rd_byte[7]}}, rd_byte}
                                        : {{(TAM-8){1'b0}}, rd_byte};

    always_comb begin
        merged = hold_q;
        if (lane_q) merged[15:8] = byte_q;
        else        merged[7:0]  = byte_q;
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = DDATA_CORE_addr;
        mem_wdata = DDATA_CORE_in;
        case (state_q)
            IDLE: begin
                if (DDATA_CORE_write) begin
                    if (DDATA_CORE_ctrl[0]) state_d = RMW;
                    else                    mem_we  = 1'b1;
                    // a colliding load is dropped, out keeps its value
                    if (DDATA_CORE_load) err_d = 1'b1;
                end else if (DDATA_CORE_load) begin
                    out_d = DDATA_CORE_ctrl[0] ? rd_ext : rd_word;
                end
            end
            RMW: begin
                state_d   = IDLE;
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = merged;
            end
            default: state_d = IDLE;
        endcase
        // reset aborts any pending merge and ignores requests
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_wr) begin
            addr_q <= DDATA_CORE_addr;
            byte_q <= DDATA_CORE_in[7:0];
            lane_q <= DDATA_CORE_ctrl[1];
            hold_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign DDATA_CORE_out  = out_q;
    assign DDATA_CORE_busy = (state_q == RMW);
    assign DDATA_CORE_err  = err_q;
endmodule

// File: tb/tb_nrisc_ddata_mem.sv
// Directed bench for nrisc_ddata_mem: word/byte access, extension, busy, collision, reset mid-RMW.
module tb_nrisc_ddata_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic [15:0] din;
    logic        load, write;
    logic [2:0]  ctrl;
    logic [15:0] dout;
    logic        busy, err;

    int tests = 0;
    int fails = 0;

    nrisc_ddata_mem #(.TAM(16), .N_DData(10)) dut (
        .clk(clk), .rst(rst),
        .DDATA_CORE_addr(addr), .DDATA_CORE_in(din),
        .DDATA_CORE_load(load), .DDATA_CORE_write(write), .DDATA_CORE_ctrl(ctrl),
        .DDATA_CORE_out(dout), .DDATA_CORE_busy(busy), .DDATA_CORE_err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        load = 0; write = 0; ctrl = 3'b000; din = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [2:0] c);
        addr = a; din = d; ctrl = c; write = 1; load = 0;
        step();
        idle_in();
    endtask

    task automatic rd(input logic [9:0] a, input logic [2:0] c);
        addr = a; ctrl = c; load = 1; write = 0;
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        addr = '0;
        rst = 1;
        step(); step();
        rst = 0;
        check("rst_out", dout, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);

        // word store then load
        wr(10'd5, 16'hBEEF, 3'b000);
        check("wstore_busy", {15'd0, busy}, 16'd0);
        rd(10'd5, 3'b000);
        check("wload", dout, 16'hBEEF);
        check("wload_busy", {15'd0, busy}, 16'd0);

        // byte store, high lane
        wr(10'd5, 16'h0012, 3'b011);
        check("bstore_busy1", {15'd0, busy}, 16'd1);
        step();
        check("bstore_busy0", {15'd0, busy}, 16'd0);
        rd(10'd5, 3'b000);
        check("bstore_hi", dout, 16'h12EF);

        // byte load extension
        wr(10'd7, 16'h80FF, 3'b000);
        rd(10'd7, 3'b001);
        check("bload_lo_zext", dout, 16'h00FF);
        rd(10'd7, 3'b101);
        check("bload_lo_sext", dout, 16'hFFFF);
        rd(10'd7, 3'b111);
        check("bload_hi_sext", dout, 16'hFF80);
        rd(10'd7, 3'b011);
        check("bload_hi_zext", dout, 16'h0080);

        // store ignored while busy; low-lane merge
        wr(10'd9, 16'h2222, 3'b000);
        wr(10'd5, 16'h0034, 3'b001);
        check("rmw_busy", {15'd0, busy}, 16'd1);
        wr(10'd9, 16'h1111, 3'b000);
        check("rmw_done", {15'd0, busy}, 16'd0);

        // collision: store wins, load dropped, err sticky
        addr = 10'd3; din = 16'h4242; ctrl = 3'b000; load = 1; write = 1;
        step();
        idle_in();
        check("coll_out_hold", dout, 16'h0080);
        check("coll_err", {15'd0, err}, 16'd1);
        step();
        check("err_sticky", {15'd0, err}, 16'd1);
        rd(10'd9, 3'b000);
        check("busy_ignored", dout, 16'h2222);
        rd(10'd5, 3'b000);
        check("bstore_lo", dout, 16'h1234);
        rd(10'd3, 3'b000);
        check("coll_store", dout, 16'h4242);

        // top address, no aliasing with 0
        wr(10'h3FF, 16'h0F0F, 3'b000);
        wr(10'h000, 16'h1357, 3'b000);
        rd(10'h3FF, 3'b000);
        check("top_addr", dout, 16'h0F0F);
        rd(10'h000, 3'b000);
        check("addr0", dout, 16'h1357);

        // reset during RMW
        wr(10'd2, 16'hAAAA, 3'b000);
        wr(10'd2, 16'h0055, 3'b001);
        check("rst_rmw_busy", {15'd0, busy}, 16'd1);
        rst = 1;
        step();
        rst = 0;
        check("rst_rmw_out", dout, 16'h0000);
        check("rst_rmw_busy0", {15'd0, busy}, 16'd0);
        check("rst_rmw_err", {15'd0, err}, 16'd0);
        rd(10'd2, 3'b000);
        check("rst_rmw_mem", dout, 16'hAAAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
